spi_slave_dx: RTL and testbench
===============================

Name: spi_slave_dx

Overview:
- Parametrised full-duplex SPI slave; next generation of the input-only SPI slave.
- Oversamples SCK/CS/MOSI in the system clock domain and supports all four CPOL/CPHA modes.
- Receives back-to-back words in one CS frame and shifts a host-loaded word out on MISO.
- Adds an inter-edge timeout and status flags; sits between the external SPI pins and the register/PID core.

Parameters:
- BITS, 32, word length in bits (>=2); MSB first on both lines.
- CPOL, 0, SCK idle level.
- CPHA, 1, 0 = sample on leading edge; 1 = sample on trailing edge. The default (CPOL 0, CPHA 1) samples on the SCK falling edge.
- INVERT_MOSI, 1, 1 = store the complement of MOSI (keeps the existing board wiring).
- SYNC_STAGES, 2, synchroniser depth for cs/sck/mosi (>=2).
- TIMEOUT, 1023, clk cycles allowed between SCK edges mid-word; 0 disables the timeout.
- FILL, 0, bit value shifted out when no TX word is pending.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- cs  in  1  chip select, active low, asynchronous pin
- sck  in  1  SPI clock, asynchronous pin
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- miso_oe  out  1  MISO output enable
- rx_data  out  BITS  last complete received word
- rx_valid  out  1  one-cycle pulse when rx_data updates
- tx_data  in  BITS  word to transmit
- tx_load  in  1  capture tx_data when tx_ready=1
- tx_ready  out  1  TX pending slot empty
- busy  out  1  high while a word is partially shifted
- tx_underrun  out  1  sticky flag: a word started with no TX pending
- timeout  out  1  one-cycle pulse when a partial word is abandoned

Behaviour:
Reset:
- reset_n=0 at a clk edge clears all state.
- rx_data=0, rx_valid=0, busy=0, tx_underrun=0, timeout=0, miso=FILL, miso_oe=0, tx_ready=1.
- State goes to IDLE, bit counter to 0, synchroniser flops to their idle values (cs=1, sck=CPOL).

Input synchronisation and edge detection:
- cs, sck and mosi each pass through SYNC_STAGES flops.
- Edges are detected by comparing the synchronised sck with its previous value.
- Leading edge = transition away from CPOL. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.

FSM:
- IDLE: synced cs=1. miso_oe=0, busy=0.
  - On synced cs falling, go to ACTIVE with the counter at 0.
  - If CPHA=0, load the TX shift register at the same time (see TX path).
- ACTIVE: miso_oe=1.
  - Sample edge: shift rx_shift left, inserting mosi XOR INVERT_MOSI; counter increments.
  - Counter at BITS-1 on a sample edge: rx_data <= completed word and rx_valid=1 on the next cycle; counter wraps to 0. The frame stays ACTIVE for back-to-back words.
  - busy = 1 while the counter is nonzero.
- Synced cs rising in any state returns to IDLE:
  - A partial word is discarded: no rx_valid, counter reset to 0, busy=0.
  - tx_underrun clears.
- Timeout, when TIMEOUT>0 and the counter is nonzero:
  - A cycle counter runs and resets on every sck edge.
  - On reaching TIMEOUT: pulse timeout, clear counter and rx_shift, busy=0, stay ACTIVE.
- Simultaneous cs rise and final sample edge in the same cycle: cs wins; the word is discarded.

TX path:
- tx_load with tx_ready=1: the pending register captures tx_data and tx_ready goes to 0 on the next cycle.
- tx_load with tx_ready=0 is ignored; no change.
- Word start:
  - CPHA=0: at the cs fall, and on the cycle after each final sample edge.
  - CPHA=1: on the first shift edge of a word.
- At word start, if a word is pending: tx_shift <= pending and tx_ready becomes 1.
- At word start with nothing pending: tx_shift is filled with FILL and tx_underrun is set (sticky).
- Each subsequent shift edge shifts tx_shift left.
- miso = tx_shift MSB while miso_oe=1, otherwise FILL.
- tx_load coincident with a word start is captured for the next word, not the current one.

Latency:
- A pin transition is seen after SYNC_STAGES+1 clk cycles.
- rx_valid rises 1 cycle after the synced final sample edge.
- SCK must be at most clk/(2*(SYNC_STAGES+2)).

Test Plan:
- BITS=8, default mode; reset_n low for 2 clks, then drive cs low and clock 0x5A on MOSI, then cs high -> rx_data=0xA5 (inverted), exactly one rx_valid pulse, busy=0 afterwards.
- Load tx_data=0xC3 before cs falls; transfer one word in each of the four CPOL/CPHA builds (INVERT_MOSI=0) -> master reads 0xC3 on MISO, tx_ready returns to 1 at word start, tx_underrun stays 0.
- Three back-to-back words 0x01, 0x80, 0xFF in one CS frame, with no TX loaded -> three rx_valid pulses with matching data, MISO all FILL, tx_underrun=1 until cs rises.
- Drop cs after 5 bits, then send a full 0x3C -> no rx_valid for the partial word; next rx_valid carries 0x3C.
- TIMEOUT=16: stop SCK after 3 bits for 20 clks, then send 8 bits of 0x96 -> one timeout pulse, busy falls, then rx_data=0x96.
- Assert reset_n low mid-word (bit 4) -> all outputs take reset values on the next clk edge; the following full word is received correctly.

Source files
------------

// File: rtl/spi_slave_dx.sv
// spi_slave_dx: oversampled full-duplex SPI slave.
// All four CPOL/CPHA modes. Back-to-back words in one CS frame.
// A one-deep TX pending slot feeds MISO. An inter-edge timeout drops partial words.
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   cs, sck, mosi         asynchronous SPI pins (cs active low)
//   miso, miso_oe         SPI data out and its output enable
//   rx_data, rx_valid     last complete received word, one-cycle update pulse
//   tx_data, tx_load      word to send, captured when tx_ready=1
//   tx_ready              TX pending slot empty
//   busy                  a word is partially shifted
//   tx_underrun           sticky: a word started with nothing pending (cleared by cs rise)
//   timeout               one-cycle pulse when a partial word is abandoned
module spi_slave_dx #(
    parameter int BITS        = 32,
    parameter int CPOL        = 0,
    parameter int CPHA        = 1,
    parameter int INVERT_MOSI = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023,
    parameter int FILL        = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cs,
    input  logic            sck,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    input  logic [BITS-1:0] tx_data,
    input  logic            tx_load,
    output logic            tx_ready,
    output logic            busy,
    output logic            tx_underrun,
    output logic            timeout
);
    // state  | meaning
    // IDLE   | cs deasserted; miso released, bit counter held at 0
    // ACTIVE | cs asserted; words are shifted back to back until cs rises

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam int            CW       = $clog2(BITS);
    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          SCK_IDLE = 1'(CPOL);
    localparam logic          FILL_BIT = 1'(FILL);
    localparam logic          MOSI_XOR = 1'(INVERT_MOSI);

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic                   cs_prev, sck_prev;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_fall, cs_rise;
    logic                   sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic [TW-1:0]          to_cnt;
    logic [BITS-1:0]        rx_shift, rx_next, tx_shift, tx_pend;
    logic                   word_done, word_start, tx_shift_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_sync   <= '1;
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            sck_prev  <= SCK_IDLE;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_prev   <= cs_s;
            sck_prev  <= sck_s;
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign cs_fall     = cs_prev & ~cs_s;
    assign cs_rise     = ~cs_prev & cs_s;
    assign sck_edge    = sck_s ^ sck_prev;
    assign lead_edge   = sck_edge & (sck_prev == SCK_IDLE);
    assign trail_edge  = sck_edge & (sck_prev != SCK_IDLE);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

    assign rx_next = {rx_shift[BITS-2:0], mosi_s ^ MOSI_XOR};

    // CPHA=0 must present the MSB before the first sample edge, so a word is
    // loaded at cs fall and right after each completed word. CPHA=1 loads on
    // the leading edge that opens a word. That edge is the shift edge seen
    // while the bit counter is still 0.
    assign word_start = (CPHA == 0)
        ? ((state == IDLE && cs_fall) || (state == ACTIVE && word_done && !cs_rise))
        : (state == ACTIVE && !cs_rise && shift_edge && bit_cnt == '0);
    assign tx_shift_en = (state == ACTIVE) && !cs_rise && shift_edge && (bit_cnt != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            miso_oe   <= 1'b0;
            bit_cnt   <= '0;
            to_cnt    <= TO_LOAD;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            timeout   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            timeout   <= 1'b0;
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    miso_oe <= 1'b0;
                    bit_cnt <= '0;
                    to_cnt  <= TO_LOAD;
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        miso_oe  <= 1'b1;
                        rx_shift <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // cs wins over a coincident final sample: the word is dropped
                        state    <= IDLE;
                        miso_oe  <= 1'b0;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        to_cnt   <= TO_LOAD;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        to_cnt   <= TO_LOAD;
                        if (bit_cnt == CNT_LAST) begin
                            rx_data   <= rx_next;
                            rx_valid  <= 1'b1;
                            word_done <= 1'b1;
                            bit_cnt   <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sck_edge || bit_cnt == '0) begin
                        to_cnt <= TO_LOAD;
                    end else if (TIMEOUT > 0) begin
                        if (to_cnt == '0) begin
                            timeout  <= 1'b1;
                            bit_cnt  <= '0;
                            rx_shift <= '0;
                            to_cnt   <= TO_LOAD;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Consuming the pending word needs tx_ready=0 and capturing a new one
    // needs tx_ready=1. The two never collide, so a load coincident with a
    // word start lands in the slot for the following word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_shift    <= {BITS{FILL_BIT}};
            tx_pend     <= '0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
        end else begin
            if (word_start) begin
                if (!tx_ready) begin
                    tx_shift <= tx_pend;
                    tx_ready <= 1'b1;
                end else begin
                    tx_shift    <= {BITS{FILL_BIT}};
                    tx_underrun <= 1'b1;
                end
            end else if (tx_shift_en) begin
                tx_shift <= {tx_shift[BITS-2:0], FILL_BIT};
            end
            if (tx_load && tx_ready) begin
                tx_pend  <= tx_data;
                tx_ready <= 1'b0;
            end
            if (cs_rise) begin
                tx_underrun <= 1'b0;
            end
        end
    end

    assign busy = (bit_cnt != '0);
    assign miso = miso_oe ? tx_shift[BITS-1] : FILL_BIT;

endmodule

// File: tb/tb_spi_slave_dx.sv
// Bench for spi_slave_dx. Four 8-bit instances cover the CPOL/CPHA modes
// with MOSI stored as received. A fifth instance uses the default mode with
// MOSI inverted and TIMEOUT=16. The master is a bit-banged task. Each frame
// is checked against a word-level model: received word, MISO word, pending
// slot and the count of word starts.
module tb_spi_slave_dx;
    localparam int HP   = 6;   // SCK half period in clk cycles
    localparam int SYNC = 2;

    logic       clk;
    logic       reset_n;
    logic [4:0] cs_p, sck_p, mosi_p, tx_load_p;
    logic [4:0][7:0] tx_data_p;
    logic [4:0] miso_w, miso_oe_w, rx_valid_w, tx_ready_w, busy_w, tx_underrun_w, timeout_w;
    logic [4:0][7:0] rx_data_w;

    int n_chk  = 0;
    int n_pass = 0;
    int vcnt[5];
    int tcnt[5];

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_dx #(.BITS(8), .CPOL(g / 2), .CPHA(g % 2), .INVERT_MOSI(0)) u_dut (
            .clk(clk), .reset_n(reset_n), .cs(cs_p[g]), .sck(sck_p[g]), .mosi(mosi_p[g]),
            .miso(miso_w[g]), .miso_oe(miso_oe_w[g]), .rx_data(rx_data_w[g]),
            .rx_valid(rx_valid_w[g]), .tx_data(tx_data_p[g]), .tx_load(tx_load_p[g]),
            .tx_ready(tx_ready_w[g]), .busy(busy_w[g]), .tx_underrun(tx_underrun_w[g]),
            .timeout(timeout_w[g]));
    end

    spi_slave_dx #(.BITS(8), .TIMEOUT(16)) u_main (
        .clk(clk), .reset_n(reset_n), .cs(cs_p[4]), .sck(sck_p[4]), .mosi(mosi_p[4]),
        .miso(miso_w[4]), .miso_oe(miso_oe_w[4]), .rx_data(rx_data_w[4]),
        .rx_valid(rx_valid_w[4]), .tx_data(tx_data_p[4]), .tx_load(tx_load_p[4]),
        .tx_ready(tx_ready_w[4]), .busy(busy_w[4]), .tx_underrun(tx_underrun_w[4]),
        .timeout(timeout_w[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rx_valid_w[i]) vcnt[i] <= vcnt[i] + 1;
            if (timeout_w[i])  tcnt[i] <= tcnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic cpol_of(input int i);
        return (i < 4) ? 1'(i / 2) : 1'b0;
    endfunction

    function automatic int cpha_of(input int i);
        return (i < 4) ? i % 2 : 1;
    endfunction

    // Master: drives nbits of w MSB first, returns what it sampled on MISO.
    // Returns HP cycles after the last SCK edge.
    task automatic xfer(input int idx, input logic [7:0] w, input int nbits, output logic [7:0] got);
        logic pol;
        pol = cpol_of(idx);
        got = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            if (cpha_of(idx) == 0) begin
                mosi_p[idx] = w[7-b];
                tick(HP);
                got = {got[6:0], miso_w[idx]};
                sck_p[idx] = ~pol;
                tick(HP);
                sck_p[idx] = pol;
            end else begin
                sck_p[idx]  = ~pol;
                mosi_p[idx] = w[7-b];
                tick(HP);
                got = {got[6:0], miso_w[idx]};
                sck_p[idx] = pol;
                tick(HP);
            end
        end
        if (cpha_of(idx) == 0) tick(HP);
    endtask

    // One CS frame of n words, optionally preloading one TX word.
    // Model: received = sent ^ inversion mask. The first word started carries
    // the preloaded word and every later one carries FILL (0). Underrun holds
    // once more words have started than were loaded. CPHA=0 starts a word at
    // the cs fall and again after every completed word. CPHA=1 starts one on
    // the opening edge of each word.
    task automatic run_frame(input int idx, input int n, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input bit do_load, input logic [7:0] txw);
        logic [7:0] ws [3];
        logic [7:0] got, inv, exp_miso;
        int base, starts, loaded;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        inv    = (idx == 4) ? 8'hFF : 8'h00;
        loaded = do_load ? 1 : 0;
        chk("tx_ready_idle", tx_ready_w[idx], 1);
        if (do_load) begin
            tx_data_p[idx] = txw;
            tx_load_p[idx] = 1'b1;
            tick(1);
            tx_load_p[idx] = 1'b0;
            tick(1);
            chk("tx_ready_loaded", tx_ready_w[idx], 0);
        end
        base = vcnt[idx];
        cs_p[idx] = 1'b0;
        tick(HP);
        for (int k = 0; k < n; k++) begin
            xfer(idx, ws[k], 8, got);
            exp_miso = (k == 0 && do_load) ? txw : 8'h00;
            chk("miso_word", got, exp_miso);
            chk("rx_count", vcnt[idx] - base, k + 1);
            chk("rx_data", rx_data_w[idx], ws[k] ^ inv);
            chk("busy_word_end", busy_w[idx], 0);
            chk("tx_ready_after_start", tx_ready_w[idx], 1);
            starts = (cpha_of(idx) == 0) ? k + 2 : k + 1;
            chk("underrun", tx_underrun_w[idx], (starts > loaded) ? 1 : 0);
        end
        cs_p[idx] = 1'b1;
        tick(SYNC + 3);
        chk("underrun_clear", tx_underrun_w[idx], 0);
        chk("miso_oe_idle", miso_oe_w[idx], 0);
        chk("miso_idle", miso_w[idx], 0);
        chk("rx_count_frame", vcnt[idx] - base, n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;
        int base, tbase, idx, nw;
        bit ld;

        reset_n   = 1'b0;
        cs_p      = '1;
        sck_p     = 5'b01100;
        mosi_p    = '0;
        tx_load_p = '0;
        tx_data_p = '0;
        tick(2);
        chk("rst_rx_data", rx_data_w[4], 0);
        chk("rst_tx_ready", tx_ready_w[4], 1);
        chk("rst_miso_oe", miso_oe_w[4], 0);
        chk("rst_busy", busy_w[4], 0);
        reset_n = 1'b1;
        tick(SYNC + 2);

        // inverted default-mode receive
        run_frame(4, 1, 8'h5A, 8'h00, 8'h00, 0, 8'h00);

        // TX word in every mode
        for (int m = 0; m < 4; m++) run_frame(m, 1, 8'($urandom), 8'h00, 8'h00, 1, 8'hC3);

        // back-to-back words, no TX loaded
        run_frame(1, 3, 8'h01, 8'h80, 8'hFF, 0, 8'h00);

        // partial word dropped by cs, then a full word (mosi inverted in u_main)
        base = vcnt[4];
        cs_p[4] = 1'b0;
        tick(HP);
        xfer(4, 8'hFF, 5, got);
        chk("busy_partial", busy_w[4], 1);
        cs_p[4] = 1'b1;
        tick(SYNC + 3);
        chk("busy_after_cs", busy_w[4], 0);
        chk("partial_no_valid", vcnt[4] - base, 0);
        run_frame(4, 1, 8'hC3, 8'h00, 8'h00, 0, 8'h00);
        chk("partial_next_word", rx_data_w[4], 8'h3C);

        // timeout after 3 bits, then a full word in the same frame
        base  = vcnt[4];
        tbase = tcnt[4];
        cs_p[4] = 1'b0;
        tick(HP);
        xfer(4, 8'h00, 3, got);
        chk("busy_before_timeout", busy_w[4], 1);
        chk("no_early_timeout", tcnt[4] - tbase, 0);
        tick(20);
        chk("timeout_pulses", tcnt[4] - tbase, 1);
        chk("busy_after_timeout", busy_w[4], 0);
        chk("timeout_no_valid", vcnt[4] - base, 0);
        xfer(4, 8'h69, 8, got);
        chk("timeout_next_count", vcnt[4] - base, 1);
        chk("timeout_next_word", rx_data_w[4], 8'h96);
        chk("timeout_single", tcnt[4] - tbase, 1);
        cs_p[4] = 1'b1;
        tick(SYNC + 3);

        // randomized frames across all instances
        for (int r = 0; r < 12; r++) begin
            idx = $urandom_range(0, 4);
            nw  = $urandom_range(1, 3);
            ld  = 1'($urandom_range(0, 1));
            run_frame(idx, nw, 8'($urandom), 8'($urandom), 8'($urandom), ld, 8'($urandom));
        end
        for (int m = 0; m < 4; m++) chk("mode_no_timeout", tcnt[m], 0);

        // reset mid-word, then a full word with cs still low
        cs_p[4] = 1'b0;
        tick(HP);
        xfer(4, 8'hA0, 4, got);
        chk("mid_busy", busy_w[4], 1);
        chk("mid_underrun", tx_underrun_w[4], 1);
        reset_n = 1'b0;
        tick(1);
        chk("mrst_rx_data", rx_data_w[4], 0);
        chk("mrst_rx_valid", rx_valid_w[4], 0);
        chk("mrst_busy", busy_w[4], 0);
        chk("mrst_underrun", tx_underrun_w[4], 0);
        chk("mrst_timeout", timeout_w[4], 0);
        chk("mrst_miso", miso_w[4], 0);
        chk("mrst_miso_oe", miso_oe_w[4], 0);
        chk("mrst_tx_ready", tx_ready_w[4], 1);
        reset_n = 1'b1;
        base = vcnt[4];
        tick(SYNC + 3 + HP);
        chk("post_rst_active", miso_oe_w[4], 1);
        xfer(4, 8'h3B, 8, got);
        chk("post_rst_count", vcnt[4] - base, 1);
        chk("post_rst_word", rx_data_w[4], 8'hC4);
        cs_p[4] = 1'b1;
        tick(SYNC + 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
